// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared IFU/LSU RAM port; gnt is combinational, responses return one cycle later.
// Backpressure: a requester that is not granted holds req and its request fields until gnt.
module mem_port_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int WordSize  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifu_req,
    input  logic [AddrWidth-1:0] ifu_addr,
    input  logic                 ifu_flush,
    output logic                 ifu_gnt,
    output logic                 ifu_rvalid,
    output logic [DataWidth-1:0] ifu_rdata,
    input  logic                 lsu_req,
    input  logic                 lsu_we,
    input  logic [1:0]           lsu_size,
    input  logic [AddrWidth-1:0] lsu_addr,
    input  logic [DataWidth-1:0] lsu_wdata,
    input  logic [WordSize-1:0]  lsu_wstrb,
    output logic                 lsu_gnt,
    output logic                 lsu_rvalid,
    output logic [DataWidth-1:0] lsu_rdata,
    output logic                 lsu_err,
    output logic [AddrWidth-1:0] ram_address,
    output logic                 ram_read_enable,
    output logic [WordSize-1:0]  ram_write_strobe,
    output logic [DataWidth-1:0] ram_write_data,
    input  logic [DataWidth-1:0] ram_read_data
);

    localparam logic [AddrWidth-1:0] WordMask = {{(AddrWidth-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        LSU_NONE,
        LSU_LOAD,
        LSU_STORE,
        LSU_ERR
    } lsu_owner_t;

    lsu_owner_t lsu_owner, lsu_owner_nxt;
    logic       ifu_pend, ifu_pend_nxt;
    logic       prio, prio_nxt;
    logic       lsu_misal, lsu_ram_req, ifu_win, lsu_win;

    // Misaligned LSU requests are answered locally and never reach the RAM.
    assign lsu_misal   = lsu_req && (lsu_size[1] ? (lsu_addr[1:0] != 2'b00)
                                                 : (lsu_size[0] & lsu_addr[0]));
    assign lsu_ram_req = lsu_req && !lsu_misal;
    assign ifu_win     = ifu_req && (!lsu_ram_req || !prio);
    assign lsu_win     = lsu_ram_req && (!ifu_req || prio);

    always_comb begin
        ifu_gnt          = ifu_win;
        lsu_gnt          = lsu_win || lsu_misal;
        ram_address      = '0;
        ram_read_enable  = 1'b0;
        ram_write_strobe = '0;
        ram_write_data   = '0;
        prio_nxt         = prio;
        ifu_pend_nxt     = ifu_win && !ifu_flush;
        lsu_owner_nxt    = LSU_NONE;

        if (ifu_win) begin
            ram_address     = ifu_addr & WordMask;
            ram_read_enable = 1'b1;
            prio_nxt        = 1'b1;
        end else if (lsu_win) begin
            ram_address = lsu_addr & WordMask;
            prio_nxt    = 1'b0;
            if (lsu_we) begin
                ram_write_strobe = lsu_wstrb;
                ram_write_data   = lsu_wdata;
            end else begin
                ram_read_enable = 1'b1;
            end
        end

        if (lsu_misal) begin
            lsu_owner_nxt = LSU_ERR;
        end else if (lsu_win) begin
            lsu_owner_nxt = lsu_we ? LSU_STORE : LSU_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio      <= 1'b1;
            ifu_pend  <= 1'b0;
            lsu_owner <= LSU_NONE;
        end else begin
            prio      <= prio_nxt;
            ifu_pend  <= ifu_pend_nxt;
            lsu_owner <= lsu_owner_nxt;
        end
    end

    // A flush in the response cycle still kills the fetch already in flight.
    always_comb begin
        ifu_rvalid = ifu_pend && !ifu_flush;
        ifu_rdata  = ifu_rvalid ? ram_read_data : '0;
        lsu_rvalid = (lsu_owner != LSU_NONE);
        lsu_err    = (lsu_owner == LSU_ERR);
        lsu_rdata  = (lsu_owner == LSU_LOAD) ? ram_read_data : '0;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single synchronous data/instruction RAM port between the instruction-fetch unit (IFU) and the memory-access stage (LSU). It runs a round-robin grant with one-cycle read latency and tracks the owner of each in-flight access so the response returns to the correct requester. It also rejects misaligned LSU accesses and drops flushed fetch responses. It sits between the CPU pipeline and the RAM bundle.

## Interface
- AddrWidth, 32, address width
- DataWidth, 32, data width
- WordSize, 4, byte strobes per word
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req  in  1  fetch request; held with ifu_addr until ifu_gnt
- ifu_addr  in  AddrWidth  fetch address (word aligned)
- ifu_flush  in  1  discard any fetch response due next cycle
- ifu_gnt  out  1  fetch accepted this cycle (combinational)
- ifu_rvalid  out  1  fetch data valid (registered)
- ifu_rdata  out  DataWidth  fetch data
- lsu_req  in  1  data request; held with all lsu_* inputs until lsu_gnt
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 half, 10/11 word
- lsu_addr  in  AddrWidth  data address
- lsu_wdata  in  DataWidth  store data, already lane-aligned
- lsu_wstrb  in  WordSize  store byte strobes
- lsu_gnt  out  1  data request accepted this cycle (combinational)
- lsu_rvalid  out  1  load data / store ack / error valid (registered)
- lsu_rdata  out  DataWidth  raw load word (0 for store or error)
- lsu_err  out  1  misaligned access, qualifies lsu_rvalid
- ram_address  out  AddrWidth  RAM address, {addr[31:2],2'b00}
- ram_read_enable  out  1  RAM read this cycle
- ram_write_strobe  out  WordSize  RAM byte write enables
- ram_write_data  out  DataWidth  RAM write data
- ram_read_data  in  DataWidth  RAM data, valid one cycle after read

## Operation
- Misaligned LSU: size 01 with addr[0]=1, or size 1x with addr[1:0]!=0. Granted immediately, no RAM access, does not take part in arbitration, prio unchanged; next cycle lsu_rvalid=1, lsu_err=1, lsu_rdata=0. IFU may be granted the same cycle.
- Arbitration among RAM-using requests (IFU, aligned LSU); one grant per cycle max:
  - only one requesting: grant it; prio <= the other side.
  - both requesting: grant side named by prio; prio <= the other side.
  - prio register: 0 = IFU, 1 = LSU; reset value 1 (LSU wins first contention).
- Granted IFU: ram_read_enable=1, strobe 0.
- Granted LSU load: ram_read_enable=1, strobe 0. Granted LSU store: ram_read_enable=0, ram_write_strobe=lsu_wstrb, ram_write_data=lsu_wdata.
- No grant: ram_address, ram_write_data, strobe, read_enable all 0.
- Response tracker: registered owner (none/IFU/LSU-load/LSU-store/LSU-err) captured at grant, consumed next cycle.
  - IFU: ifu_rvalid=1, ifu_rdata=ram_read_data, unless ifu_flush was high in the grant cycle or the response cycle, in which case ifu_rvalid=0.
  - LSU load: lsu_rvalid=1, lsu_rdata=ram_read_data, lsu_err=0.
  - LSU store: lsu_rvalid=1, lsu_rdata=0, lsu_err=0 (write ack).
- Fully pipelined: new grants are allowed in the same cycle a previous response is delivered.

## Timing
- Reset (rst=0, async): prio=1, tracker empty, ifu_rvalid=lsu_rvalid=lsu_err=0, ifu_rdata=lsu_rdata=0. Any in-flight response is discarded, and no rvalid is produced after reset is released. Combinational outputs follow inputs with the tracker empty.
- gnt is combinational in the cycle of acceptance. The rvalid/err response pulses exactly one cycle later for one cycle.
- Sustained contention alternates grants IFU/LSU each cycle; neither side waits more than 1 cycle.
- A request that is not granted must stay asserted and stable. Dropping req before gnt is legal, and no access occurs.
- ifu_flush without an outstanding fetch has no effect. Flush does not block a new IFU grant in the same cycle.

## Test plan
- Reset then ifu_req only, addr 0x100, RAM word 0x00000013 -> ifu_gnt same cycle, ram_read_enable=1, ram_address=0x100; next cycle ifu_rvalid=1, ifu_rdata=0x00000013.
- ifu_req and lsu load 0x200 both held from reset -> grants LSU, IFU, LSU, IFU on consecutive cycles; each rvalid one cycle after its grant with the matching RAM data.
- LSU store addr 0x204, wstrb 4'b1100, wdata 0xABCD0000 -> ram_write_strobe=4'b1100, ram_read_enable=0; next cycle lsu_rvalid=1, lsu_rdata=0, lsu_err=0.
- LSU half load at 0x203 with ifu_req at 0x40 in the same cycle -> lsu_gnt=1 and ifu_gnt=1, RAM reads 0x40 only; next cycle lsu_rvalid=1, lsu_err=1, ifu_rvalid=1.
- IFU granted at 0x80, ifu_flush=1 in the following cycle -> ifu_rvalid stays 0; a new IFU request granted that cycle returns normally.
- LSU load granted, rst asserted low before the response cycle -> lsu_rvalid=0 throughout and after release; prio=1 (LSU wins the next contention).
